// File: rtl/clock_ctrl.sv
// Tick prescaler, button debounce and time-set FSM for the BCD clock.
// CLOCK_CTRL_AUTOREPEAT_EN adds inc auto-repeat while held in SET states.
module clock_ctrl #(
  parameter int CLK_FREQ_HZ     = 1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic [3:0] hours_high_i,
  input  logic [3:0] hours_low_i,
  input  logic [3:0] minutes_high_i,
  input  logic [3:0] minutes_low_i,
  output logic       tick_o,
  output logic       load_o,
  output logic [3:0] load_hours_high_o,
  output logic [3:0] load_hours_low_o,
  output logic [3:0] load_minutes_high_o,
  output logic [3:0] load_minutes_low_o,
  output logic [1:0] state_o,
  output logic       blink_o
);

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam int BW = $clog2(CLK_FREQ_HZ / 2);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2,
    COMMIT      = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]    raw, sync1, sync2, db, db_q, ev, armed;
  logic [DW-1:0] dcnt [2];
  logic          v1, v2;
  logic          rep, mode_ev, inc_ev, in_set, entering;

  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic          blink_q;

  logic [3:0] hh, hl, mh, ml;
  logic [3:0] hh_n, hl_n, mh_n, ml_n;

  assign raw = {inc_btn_i, mode_btn_i};

  // armed blocks a press that was already held when reset released
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_q    <= '0;
      ev      <= '0;
      armed   <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      v1    <= 1'b1;
      v2    <= v1;
      db_q  <= db;
      ev    <= db & ~db_q & armed;
      armed <= armed | ({2{v2}} & ~sync2 & ~db);
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == db[b]) begin
          dcnt[b] <= '0;
        end else if (dcnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[b]   <= sync2[b];
          dcnt[b] <= '0;
        end else begin
          dcnt[b] <= dcnt[b] + DW'(1);
        end
      end
    end
  end

  assign in_set  = (state_q == SET_HOURS) || (state_q == SET_MINUTES);
  assign mode_ev = ev[0];
  assign inc_ev  = (ev[1] | rep) & ~ev[0];

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  logic [PW-1:0] rcnt;
  logic          rfirst;
  logic          rep_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
      rep_q  <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (ev[1]) begin
        rcnt   <= '0;
        rfirst <= 1'b1;
      end else if (db[1] && in_set) begin
        if (rcnt == (rfirst ? PW'(CLK_FREQ_HZ - 1)
                            : PW'(CLK_FREQ_HZ / 4 - 1))) begin
          rep_q  <= 1'b1;
          rcnt   <= '0;
          rfirst <= 1'b0;
        end else begin
          rcnt <= rcnt + PW'(1);
        end
      end else begin
        rcnt <= '0;
      end
    end
  end

  assign rep = rep_q;
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:         if (mode_ev) state_d = SET_HOURS;
      SET_HOURS:   if (mode_ev) state_d = SET_MINUTES;
      SET_MINUTES: if (mode_ev) state_d = COMMIT;
      COMMIT:      state_d = RUN;
      default:     state_d = RUN;
    endcase
  end

  always_comb begin
    tick_o  = (state_q == RUN) && (presc == PW'(CLK_FREQ_HZ - 1));
    load_o  = (state_q == COMMIT);
    state_o = state_q;
    blink_o = blink_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc <= '0;
    end else if (state_q != RUN) begin
      presc <= '0;
    end else if (presc == PW'(CLK_FREQ_HZ - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign entering = (state_d != state_q) &&
                    ((state_d == SET_HOURS) || (state_d == SET_MINUTES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else if (entering) begin
      bcnt    <= '0;
      blink_q <= 1'b1;
    end else if (in_set) begin
      if (bcnt == BW'(CLK_FREQ_HZ / 2 - 1)) begin
        bcnt    <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end else begin
      bcnt    <= '0;
      blink_q <= 1'b0;
    end
  end

  // invalid BCD or past the top value wraps straight to 00
  always_comb begin
    hh_n = hh;
    hl_n = hl;
    if (hh > 4'd2 || hl > 4'd9 || (hh == 4'd2 && hl >= 4'd3)) begin
      hh_n = 4'd0;
      hl_n = 4'd0;
    end else if (hl == 4'd9) begin
      hh_n = hh + 4'd1;
      hl_n = 4'd0;
    end else begin
      hl_n = hl + 4'd1;
    end
  end

  always_comb begin
    mh_n = mh;
    ml_n = ml;
    if (mh > 4'd5 || ml > 4'd9 || (mh == 4'd5 && ml == 4'd9)) begin
      mh_n = 4'd0;
      ml_n = 4'd0;
    end else if (ml == 4'd9) begin
      mh_n = mh + 4'd1;
      ml_n = 4'd0;
    end else begin
      ml_n = ml + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hh <= '0;
      hl <= '0;
      mh <= '0;
      ml <= '0;
    end else if (state_q == RUN && mode_ev) begin
      hh <= hours_high_i;
      hl <= hours_low_i;
      mh <= minutes_high_i;
      ml <= minutes_low_i;
    end else if (state_q == SET_HOURS && inc_ev) begin
      hh <= hh_n;
      hl <= hl_n;
    end else if (state_q == SET_MINUTES && inc_ev) begin
      mh <= mh_n;
      ml <= ml_n;
    end
  end

  assign load_hours_high_o   = hh;
  assign load_hours_low_o    = hl;
  assign load_minutes_high_o = mh;
  assign load_minutes_low_o  = ml;

endmodule
